// File: rtl/m92_sample_pkg.sv
// Shared types and constants for the M92 sample-ROM fetch path.
package m92_sample_pkg;

  localparam int SAMPLE_ADDR_W = 18;
  localparam int SDR_ADDR_W    = 25;

  // Zero marks end-of-sample, so the idle byte must never be zero.
  localparam logic [7:0] DEFAULT_UNDERRUN_VALUE = 8'h80;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  function automatic logic [SDR_ADDR_W-1:0] sdr_word_addr(
    input logic [SDR_ADDR_W-1:0]    base,
    input logic [SAMPLE_ADDR_W-2:0] word_addr
  );
    return base + {{(SDR_ADDR_W-SAMPLE_ADDR_W){1'b0}}, word_addr, 1'b0};
  endfunction

endpackage

// File: rtl/sample_word_fifo.sv
// Small word FIFO feeding the sample byte selector; exposes the head and the
// entry behind it so the consumer can register its next output in one cycle.
module sample_word_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [DATA_W-1:0] second,
  output logic              full,
  output logic              empty,
  output logic              single
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign single     = (count == CNT_W'(1));
  assign do_push    = push && !flush && !full;
  assign do_pop     = pop && !flush && !empty;
  assign rd_ptr_nxt = rd_ptr + 1'b1;
  assign head       = mem[rd_ptr];
  assign second     = mem[rd_ptr_nxt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sample_rom_fetch.sv
// Prefetching byte reader: streams 16-bit SDRAM words into a FIFO and presents
// the byte at the sequencer's current address.
module sample_rom_fetch
  import m92_sample_pkg::*;
#(
  parameter logic [SDR_ADDR_W-1:0] ROM_BASE       = 25'h0,
  parameter int                    FIFO_DEPTH     = 4,
  parameter logic [7:0]            UNDERRUN_VALUE = DEFAULT_UNDERRUN_VALUE
) (
  input  logic                     CLK_32M,
  input  logic                     reset,
  input  logic [SAMPLE_ADDR_W-1:0] addr_in,
  input  logic [1:0]               addr_wr,
  input  logic                     inc,
  output logic [7:0]               sample_data,
  output logic                     sample_valid,
  output logic                     underrun,
  output logic [SDR_ADDR_W-1:0]    sdr_addr,
  output logic                     sdr_req,
  input  logic                     sdr_rdy,
  input  logic [15:0]              sdr_data
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [SAMPLE_ADDR_W-1:0] rd_addr;
  logic [SAMPLE_ADDR_W-1:0] load_addr;
  logic [SAMPLE_ADDR_W-2:0] fetch_addr;
  logic                     load;
  logic                     rd_step;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_single;
  logic [15:0]              fifo_head;
  logic [15:0]              fifo_second;
  logic                     vld_p0;
  logic [15:0]              word_p0;
  logic                     phase_p0;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic phase);
    return phase ? word[15:8] : word[7:0];
  endfunction

  // Each addr_wr bit replaces one half of the current read address.
  assign load      = |addr_wr;
  assign load_addr = {addr_wr[1] ? addr_in[17:9] : rd_addr[17:9],
                      addr_wr[0] ? addr_in[8:0]  : rd_addr[8:0]};

  // A load outranks inc; an inc only advances when a byte is present.
  assign rd_step   = inc && !load && !fifo_empty;
  assign fifo_pop  = rd_step && rd_addr[0];
  assign fifo_push = (state == REQ) && sdr_rdy && !load;

  sample_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (16)
  ) u_fifo (
    .clk    (CLK_32M),
    .reset  (reset),
    .flush  (load),
    .push   (fifo_push),
    .din    (sdr_data),
    .pop    (fifo_pop),
    .head   (fifo_head),
    .second (fifo_second),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .single (fifo_single)
  );

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A load in IDLE requests at once: the same edge empties the FIFO.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load || !fifo_full) state_nxt = REQ;
      REQ:     if (sdr_rdy)            state_nxt = IDLE;
               else if (load)          state_nxt = DISCARD;
      DISCARD: if (sdr_rdy)            state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sdr_req = (state != IDLE);
  end

  // Address is captured on request entry and held until the acknowledge.
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      sdr_addr <= ROM_BASE;
    end else if (state == IDLE && state_nxt == REQ) begin
      sdr_addr <= sdr_word_addr(ROM_BASE, load ? load_addr[17:1] : fetch_addr);
    end
  end

  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      rd_addr    <= '0;
      fetch_addr <= '0;
    end else if (load) begin
      rd_addr    <= load_addr;
      fetch_addr <= load_addr[17:1];
    end else begin
      if (rd_step)   rd_addr    <= rd_addr + 1'b1;
      if (fifo_push) fetch_addr <= fetch_addr + 1'b1;
    end
  end

  // ---- stage p0: predict the head word and phase after this cycle's push/pop
  always_comb begin
    phase_p0 = rd_step ? ~rd_addr[0] : rd_addr[0];
    if (fifo_pop) begin
      vld_p0  = fifo_push || !fifo_single;
      word_p0 = fifo_single ? sdr_data : fifo_second;
    end else begin
      vld_p0  = fifo_push || !fifo_empty;
      word_p0 = fifo_empty ? sdr_data : fifo_head;
    end
    if (load) vld_p0 = 1'b0;
  end

  // ---- stage p1: registered sample outputs
  always_ff @(posedge CLK_32M or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= UNDERRUN_VALUE;
      underrun     <= 1'b0;
    end else begin
      sample_valid <= vld_p0;
      sample_data  <= vld_p0 ? byte_sel(word_p0, phase_p0) : UNDERRUN_VALUE;
      underrun     <= inc && !load && fifo_empty;
    end
  end

endmodule

// File: tb/tb_sample_rom_fetch.sv
// Directed bench for sample_rom_fetch: vector table of address loads plus
// hand-written sequences for underrun, discard, FIFO-full and async reset.
`timescale 1ns/1ps
module tb_sample_rom_fetch;

  localparam logic [24:0] BASE  = 25'h0040000;
  localparam int          DEPTH = 4;

  logic        CLK_32M = 1'b0;
  logic        reset   = 1'b0;
  logic [17:0] addr_in = '0;
  logic [1:0]  addr_wr = '0;
  logic        inc     = 1'b0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        underrun;
  logic [24:0] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy  = 1'b0;
  logic [15:0] sdr_data = '0;

  int tests = 0;
  int fails = 0;

  logic [15:0] rom [logic [24:0]];
  logic [24:0] ack_log [$];
  int          lat     = 3;
  bit          sdr_en  = 1'b1;
  int          req_cnt = 0;

  typedef struct {
    logic [17:0] addr;
    logic [1:0]  wr;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [24:0] sdr0;
    logic [24:0] sdr1;
    int          nb;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs [6];

  always #5 CLK_32M = ~CLK_32M;

  sample_rom_fetch #(
    .ROM_BASE       (BASE),
    .FIFO_DEPTH     (DEPTH),
    .UNDERRUN_VALUE (8'h80)
  ) dut (
    .CLK_32M      (CLK_32M),
    .reset        (reset),
    .addr_in      (addr_in),
    .addr_wr      (addr_wr),
    .inc          (inc),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .sdr_addr     (sdr_addr),
    .sdr_req      (sdr_req),
    .sdr_rdy      (sdr_rdy),
    .sdr_data     (sdr_data)
  );

  function automatic logic [15:0] rom_word(input logic [24:0] a);
    if (rom.exists(a)) return rom[a];
    return {a[7:0] + 8'd1, a[7:0]};
  endfunction

  function automatic logic [24:0] ack_at(input int idx);
    if (ack_log.size() > idx) return ack_log[idx];
    return '1;
  endfunction

  // SDRAM model: acknowledges after 'lat' cycles of request, one-cycle rdy.
  initial begin
    forever begin
      @(negedge CLK_32M);
      if (reset || sdr_rdy) begin
        sdr_rdy = 1'b0;
        if (reset) req_cnt = 0;
      end else if (sdr_req && sdr_en) begin
        req_cnt++;
        if (req_cnt >= lat) begin
          sdr_rdy  = 1'b1;
          sdr_data = rom_word(sdr_addr);
          ack_log.push_back(sdr_addr);
          req_cnt  = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_32M);
  endtask

  task automatic load(input logic [17:0] a, input logic [1:0] wr, input logic with_inc);
    @(negedge CLK_32M);
    ack_log.delete();
    addr_in = a;
    addr_wr = wr;
    inc     = with_inc;
    @(negedge CLK_32M);
    addr_wr = '0;
    inc     = 1'b0;
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    @(negedge CLK_32M);
    inc = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!sample_valid && n < 60) begin
      tick();
      n++;
    end
    chk(name, sample_valid, 1);
  endtask

  task automatic quiesce();
    int idle = 0;
    int n    = 0;
    while (idle < 4 && n < 400) begin
      tick();
      n++;
      idle = sdr_req ? 0 : idle + 1;
    end
    chk("quiesce", idle >= 4, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{18'h00100, 2'b11, 16'h2211, 16'h4433, 25'h0040100, 25'h0040102, 4, 32'h44332211};
    vecs[1] = '{18'h00101, 2'b11, 16'hBBAA, 16'hDDCC, 25'h0040100, 25'h0040102, 3, 32'h00DDCCBB};
    vecs[2] = '{18'h3FFFE, 2'b11, 16'h2F1F, 16'h4F3F, 25'h007FFFE, 25'h0040000, 4, 32'h4F3F2F1F};
    vecs[3] = '{18'h3FFFF, 2'b11, 16'h6655, 16'h8877, 25'h007FFFE, 25'h0040000, 3, 32'h00887766};
    vecs[4] = '{18'h12345, 2'b11, 16'hA1B2, 16'hC3D4, 25'h0052344, 25'h0052346, 3, 32'h00C3D4A1};
    vecs[5] = '{18'h3FE10, 2'b01, 16'h0706, 16'h0908, 25'h0052210, 25'h0052212, 4, 32'h09080706};

    #2 reset = 1'b1;
    repeat (3) tick();
    chk("rst_sdr_req",      sdr_req,      0);
    chk("rst_sdr_addr",     sdr_addr,     BASE);
    chk("rst_sample_data",  sample_data,  8'h80);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_underrun",     underrun,     0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rom[vecs[i].sdr0] = vecs[i].w0;
      rom[vecs[i].sdr1] = vecs[i].w1;
      quiesce();
      load(vecs[i].addr, vecs[i].wr, 1'b0);
      chk($sformatf("v%0d_req_latency", i), sdr_req, 1);
      chk($sformatf("v%0d_sdr_addr0", i), sdr_addr, vecs[i].sdr0);
      chk($sformatf("v%0d_flushed", i), sample_valid, 0);
      wait_valid($sformatf("v%0d_valid", i));
      chk($sformatf("v%0d_byte0", i), sample_data, vecs[i].bytes[7:0]);
      repeat (30) tick();
      for (int k = 1; k < vecs[i].nb; k++) begin
        pulse_inc();
        chk($sformatf("v%0d_byte%0d", i, k), sample_data, vecs[i].bytes[8*k +: 8]);
        chk($sformatf("v%0d_valid%0d", i, k), sample_valid, 1);
      end
      chk($sformatf("v%0d_ack0", i), ack_at(0), vecs[i].sdr0);
      chk($sformatf("v%0d_ack1", i), ack_at(1), vecs[i].sdr1);
    end

    // Underrun: incs with no data, plus a load that swallows a same-cycle inc.
    rom[25'h0040100] = 16'h2211;
    quiesce();
    sdr_en = 1'b0;
    load(18'h00100, 2'b11, 1'b0);
    load(18'h00100, 2'b11, 1'b1);
    chk("A_load_inc_no_underrun", underrun, 0);
    for (int k = 0; k < 3; k++) begin
      pulse_inc();
      chk("A_underrun_pulse", underrun, 1);
      chk("A_underrun_data", sample_data, 8'h80);
      chk("A_underrun_valid", sample_valid, 0);
      tick();
      chk("A_underrun_clear", underrun, 0);
    end
    sdr_en = 1'b1;
    wait_valid("A_valid");
    chk("A_rd_addr_held", sample_data, 8'h11);

    // Reload while the request for 0x102 is outstanding: word must be dropped.
    rom[25'h0040200] = 16'h5150;
    quiesce();
    load(18'h00100, 2'b11, 1'b0);
    n = 0;
    while (ack_log.size() < 1 && n < 40) begin
      tick();
      n++;
    end
    sdr_en = 1'b0;
    n = 0;
    while (!(sdr_req && sdr_addr == 25'h0040102) && n < 40) begin
      tick();
      n++;
    end
    chk("B_req_102", sdr_addr, 25'h0040102);
    load(18'h00300, 2'b11, 1'b0);
    chk("B_hold_req", sdr_req, 1);
    chk("B_hold_addr", sdr_addr, 25'h0040102);
    chk("B_flushed", sample_valid, 0);
    load(18'h00000, 2'b01, 1'b0);
    repeat (3) tick();
    chk("B_hold_req2", sdr_req, 1);
    chk("B_hold_addr2", sdr_addr, 25'h0040102);
    sdr_en = 1'b1;
    wait_valid("B_valid");
    chk("B_first_byte", sample_data, 8'h50);
    chk("B_ack_discarded", ack_at(0), 25'h0040102);
    chk("B_ack_new", ack_at(1), 25'h0040200);

    // Fast SDRAM, no inc: fetching stops at FIFO_DEPTH words.
    lat = 1;
    quiesce();
    load(18'h00400, 2'b11, 1'b0);
    repeat (40) tick();
    chk("C_fill_count", ack_log.size(), DEPTH);
    chk("C_req_idle", sdr_req, 0);
    pulse_inc();
    pulse_inc();
    chk("C_byte_402", sample_data, 8'h02);
    repeat (20) tick();
    chk("C_refill_count", ack_log.size(), DEPTH + 1);
    chk("C_req_idle2", sdr_req, 0);
    lat = 3;

    // Asynchronous reset with data buffered and a request in flight.
    quiesce();
    load(18'h00500, 2'b11, 1'b0);
    wait_valid("D_valid");
    n = 0;
    while (!sdr_req && n < 20) begin
      tick();
      n++;
    end
    chk("D_req_pending", sdr_req, 1);
    chk("D_has_data", sample_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("D_async_req", sdr_req, 0);
    chk("D_async_valid", sample_valid, 0);
    chk("D_async_data", sample_data, 8'h80);
    chk("D_async_addr", sdr_addr, BASE);
    tick();
    reset = 1'b0;
    tick();
    chk("D_after_release_req", sdr_req, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
